// File: rtl/tmds_decoder.sv
// TMDS receive channel decoder: hunts for control tokens to find the word
// boundary, then decodes aligned 10-bit words to pixel bytes or control codes.
module tmds_decoder #(
    parameter int p_lock_tokens = 16,
    parameter int p_timeout     = 4096
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_data,
    output logic [7:0] o_data,
    output logic [1:0] o_ctrl,
    output logic       o_blank,
    output logic       o_locked,
    output logic [3:0] o_offset
);
    localparam int tok_w  = $clog2(p_lock_tokens + 1);
    localparam int idle_w = $clog2(p_timeout + 1);
    localparam logic [tok_w-1:0]  tok_max  = tok_w'(p_lock_tokens);
    localparam logic [idle_w-1:0] idle_end = idle_w'(p_timeout - 1);

    typedef enum logic {SEARCH, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [3:0]        offset_q, offset_d;
    logic [tok_w-1:0]  tok_cnt_q, tok_cnt_d;
    logic [idle_w-1:0] idle_cnt_q, idle_cnt_d;
    logic [9:0]        prev_q, prev_d;
    logic [9:0]        s1_word_q, s1_word_d;
    logic              s1_tok_q, s1_tok_d;
    logic [1:0]        s1_code_q, s1_code_d;
    logic [7:0]        data_q, data_d;
    logic [1:0]        ctrl_q, ctrl_d;
    logic              blank_q, blank_d;
    logic              locked_q, locked_d;

    logic [9:0] window;
    logic       win_tok;
    logic [1:0] win_code;
    logic [3:0] offset_next;
    logic       timeout;
    logic [7:0] d_word;
    logic [7:0] dec;

    // Bit j of {i_data, prev} is in arrival order, so shifting by the offset
    // brings the candidate word boundary to bit 0.
    always_comb begin
        window = 10'({i_data, prev_q} >> offset_q);
    end

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and infers a latch.
        win_tok  = 1'b1;
        win_code = 2'b00;
        case (window)
            10'h354: win_code = 2'b00;
            10'h0AB: win_code = 2'b01;
            10'h154: win_code = 2'b10;
            10'h2AB: win_code = 2'b11;
            default: win_tok  = 1'b0;
        endcase
    end

    always_comb begin
        offset_next = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
        timeout     = !win_tok && (idle_cnt_q == idle_end);
        state_d     = state_q;
        offset_d    = offset_q;
        tok_cnt_d   = tok_cnt_q;
        idle_cnt_d  = idle_cnt_q;
        case (state_q)
            SEARCH: begin
                if (win_tok) begin
                    idle_cnt_d = '0;
                    tok_cnt_d  = (tok_cnt_q == tok_max) ? tok_cnt_q : tok_cnt_q + tok_w'(1);
                    if (tok_cnt_d == tok_max) state_d = LOCKED;
                end else if (timeout) begin
                    offset_d   = offset_next;
                    tok_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else begin
                    tok_cnt_d  = '0;
                    idle_cnt_d = idle_cnt_q + idle_w'(1);
                end
            end
            LOCKED: begin
                if (win_tok) begin
                    idle_cnt_d = '0;
                end else if (timeout) begin
                    state_d    = SEARCH;
                    offset_d   = offset_next;
                    tok_cnt_d  = '0;
                    idle_cnt_d = '0;
                end else begin
                    idle_cnt_d = idle_cnt_q + idle_w'(1);
                end
            end
            default: state_d = SEARCH;
        endcase
    end

    always_comb begin
        prev_d    = i_data;
        s1_word_d = window;
        s1_tok_d  = win_tok;
        s1_code_d = win_code;
        locked_d  = (state_q == LOCKED);
    end

    // Undo the transmit-side conditional inversion, then the XOR/XNOR chain.
    always_comb begin
        d_word = s1_word_q[9] ? ~s1_word_q[7:0] : s1_word_q[7:0];
        dec    = '0;
        dec[0] = d_word[0];
        for (int i = 1; i < 8; i++) begin
            dec[i] = s1_word_q[8] ? (d_word[i] ^ d_word[i-1]) : ~(d_word[i] ^ d_word[i-1]);
        end
    end

    always_comb begin
        data_d  = 8'h00;
        ctrl_d  = ctrl_q;
        blank_d = 1'b1;
        if (state_q != LOCKED) begin
            ctrl_d = 2'b00;
        end else if (s1_tok_q) begin
            ctrl_d = s1_code_q;
        end else begin
            data_d  = dec;
            blank_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (i_rst) begin
            state_q    <= SEARCH;
            offset_q   <= 4'd0;
            tok_cnt_q  <= '0;
            idle_cnt_q <= '0;
            prev_q     <= 10'h000;
            s1_word_q  <= 10'h000;
            s1_tok_q   <= 1'b0;
            s1_code_q  <= 2'b00;
            data_q     <= 8'h00;
            ctrl_q     <= 2'b00;
            blank_q    <= 1'b1;
            locked_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            offset_q   <= offset_d;
            tok_cnt_q  <= tok_cnt_d;
            idle_cnt_q <= idle_cnt_d;
            prev_q     <= prev_d;
            s1_word_q  <= s1_word_d;
            s1_tok_q   <= s1_tok_d;
            s1_code_q  <= s1_code_d;
            data_q     <= data_d;
            ctrl_q     <= ctrl_d;
            blank_q    <= blank_d;
            locked_q   <= locked_d;
        end
    end

    assign o_data   = data_q;
    assign o_ctrl   = ctrl_q;
    assign o_blank  = blank_q;
    assign o_locked = locked_q;
    assign o_offset = offset_q;

endmodule

// File: tb/tb_tmds_decoder.sv
// Directed bench for tmds_decoder: alignment hunt, lock timing, decode table,
// timeout boundary, offset wrap and mid-lock reset.
module tb_tmds_decoder;
    localparam int lock_tokens = 16;
    localparam int timeout     = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [9:0] din;
    logic [7:0] o_data;
    logic [1:0] o_ctrl;
    logic       o_blank;
    logic       o_locked;
    logic [3:0] o_offset;

    int n_cmp = 0;
    int n_err = 0;

    tmds_decoder #(
        .p_lock_tokens(lock_tokens),
        .p_timeout    (timeout)
    ) dut (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_data  (din),
        .o_data  (o_data),
        .o_ctrl  (o_ctrl),
        .o_blank (o_blank),
        .o_locked(o_locked),
        .o_offset(o_offset)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [9:0] word;
        logic [7:0] data;
        logic [1:0] ctrl;
        logic       blank;
    } vec_t;

    task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_cmp++;
        if (actual !== expected) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [9:0] rotl(input logic [9:0] w, input int k);
        logic [9:0] r = w;
        for (int i = 0; i < k; i++) r = {r[8:0], r[9]};
        return r;
    endfunction

    // Outputs must be forced to blank while unlocked.
    task automatic gate_check(input string name);
        if (!o_locked) check(name, {o_blank, o_ctrl, o_data}, {1'b1, 2'b00, 8'h00});
    endtask

    task automatic reset_check(input string name);
        check(name, {o_locked, o_blank, o_ctrl, o_data, o_offset}, {1'b0, 1'b1, 2'b00, 8'h00, 4'd0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[11];
        int   chg_cyc[4];
        int   n_chg;
        int   lock_cyc;
        logic [3:0] last_off;

        vecs[0]  = '{10'h100, 8'h00, 2'b00, 1'b0};
        vecs[1]  = '{10'h2FF, 8'hFE, 2'b00, 1'b0};
        vecs[2]  = '{10'h3FF, 8'h00, 2'b00, 1'b0};
        vecs[3]  = '{10'h0AB, 8'h00, 2'b01, 1'b1};
        vecs[4]  = '{10'h154, 8'h00, 2'b10, 1'b1};
        vecs[5]  = '{10'h2AB, 8'h00, 2'b11, 1'b1};
        vecs[6]  = '{10'h1A5, 8'hEF, 2'b11, 1'b0};
        vecs[7]  = '{10'h0F0, 8'hEE, 2'b11, 1'b0};
        vecs[8]  = '{10'h354, 8'h00, 2'b00, 1'b1};
        vecs[9]  = '{10'h2C3, 8'hBA, 2'b00, 1'b0};
        vecs[10] = '{10'h155, 8'hFF, 2'b00, 1'b0};

        // Reset for two cycles with random input.
        rst = 1'b1;
        din = 10'h000;
        #1;
        for (int i = 0; i < 2; i++) begin
            din = 10'($urandom);
            tick();
            reset_check($sformatf("reset_cyc%0d", i));
        end
        rst = 1'b0;

        // Token stream delayed by 3 bits: hunt must step 0->1->2->3 then lock.
        din      = rotl(10'h354, 3);
        n_chg    = 0;
        lock_cyc = 0;
        last_off = 4'd0;
        for (int c = 1; c <= 250; c++) begin
            tick();
            if (o_offset !== last_off) begin
                if (n_chg < 4) chg_cyc[n_chg] = c;
                n_chg++;
                last_off = o_offset;
            end
            if (o_locked) begin
                lock_cyc = c;
                break;
            end
            gate_check($sformatf("hunt_gate_c%0d", c));
        end
        check("hunt_locked", o_locked, 1'b1);
        check("hunt_lock_cycle", lock_cyc, 209);
        check("hunt_offset", o_offset, 4'd3);
        check("hunt_blank_ctrl", {o_blank, o_ctrl}, {1'b1, 2'b00});
        check("hunt_n_changes", n_chg, 3);
        if (n_chg == 3) begin
            check("hunt_first_timeout", chg_cyc[0], 64);
            check("hunt_interval_1_2", chg_cyc[1] - chg_cyc[0], timeout);
            check("hunt_interval_2_3", chg_cyc[2] - chg_cyc[1], timeout);
        end

        // Mid-lock reset, then relock at offset 0 needs 16 fresh tokens.
        rst = 1'b1;
        din = 10'h354;
        tick();
        reset_check("midlock_reset");
        rst = 1'b0;
        for (int c = 1; c <= 17; c++) begin
            tick();
            gate_check($sformatf("relock_gate_c%0d", c));
        end
        check("relock_not_yet", o_locked, 1'b0);
        tick();
        check("relock_locked", o_locked, 1'b1);
        check("relock_offset", o_offset, 4'd0);

        // Decode table at offset 0: output appears three edges after the word.
        for (int i = 0; i < 13; i++) begin
            din = (i < 11) ? vecs[i].word : 10'h354;
            tick();
            if (i >= 2) begin
                check($sformatf("vec%0d_w%03h", i - 2, vecs[i-2].word),
                      {o_blank, o_ctrl, o_data},
                      {vecs[i-2].blank, vecs[i-2].ctrl, vecs[i-2].data});
            end
        end

        // 63 non-token windows then a token: lock must hold.
        for (int i = 0; i < 63; i++) begin
            din = 10'h100;
            tick();
        end
        din = 10'h354;
        for (int i = 0; i < 4; i++) tick();
        check("token_wins_locked", o_locked, 1'b1);
        check("token_wins_offset", o_offset, 4'd0);

        // 64 non-token windows: timeout drops lock and advances the offset.
        for (int i = 0; i < 64; i++) begin
            din = 10'h100;
            tick();
        end
        din = 10'h354;
        tick();
        check("timeout_offset", o_offset, 4'd1);
        check("timeout_locked_lags", o_locked, 1'b1);
        tick();
        check("timeout_unlocked", o_locked, 1'b0);
        check("timeout_forced_blank", {o_blank, o_ctrl, o_data}, {1'b1, 2'b00, 8'h00});

        // Lock at offset 9, then time out and wrap to 0.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        din = rotl(10'h354, 9);
        for (int c = 1; c <= 64 * 9 + 16 + 10; c++) begin
            tick();
            if (o_locked) break;
            gate_check($sformatf("hunt9_gate_c%0d", c));
        end
        check("hunt9_locked", o_locked, 1'b1);
        check("hunt9_offset", o_offset, 4'd9);
        for (int i = 0; i < 64; i++) begin
            din = 10'h100;
            tick();
        end
        din = rotl(10'h354, 9);
        for (int c = 0; c < 8; c++) begin
            if (!o_locked) break;
            tick();
        end
        check("wrap_unlocked", o_locked, 1'b0);
        check("wrap_offset", o_offset, 4'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
